hazard_scoreboard: RTL and testbench

//  Parametrised, stateful successor to the decode-stage stall logic.

---
 rtl/hazard_scoreboard.sv | 82 ++++++++
 tb/tb_hazard_scoreboard.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency scoreboard producing decode stall
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3,
    parameter bit WAW_STALL  = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          de_valid,
    input  logic [REG_ADDR_W-1:0]         de_src1,
    input  logic [REG_ADDR_W-1:0]         de_src2,
    input  logic                          de_use_src1,
    input  logic                          de_use_src2,
    input  logic [REG_ADDR_W-1:0]         de_rd,
    input  logic                          de_regwrt,
    input  logic [LAT_W-1:0]              de_lat,
    input  logic                          flush,
    input  logic                          mem_done,
    input  logic [REG_ADDR_W-1:0]         mem_done_rd,
    output logic                          stall_processor,
    output logic [(1<<REG_ADDR_W)-1:0]    busy_mask,
    output logic [CNT_W-1:0]              stall_cycles
);

    localparam int               NUM_REGS = 1 << REG_ADDR_W;
    // All-ones latency marks a variable-latency result that only mem_done can clear.
    localparam logic [LAT_W-1:0] PEND     = '1;

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic             haz1;
    logic             haz2;
    logic             hazw;
    logic             issue;

    // A register is busy while its counter is non-zero; entry 0 is held at zero.
    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    // Stall decode while any consumed operand (or the destination, if enabled) is not yet forwardable.
    always_comb begin
        haz1            = de_use_src1 & busy_mask[de_src1];
        haz2            = de_use_src2 & busy_mask[de_src2];
        hazw            = WAW_STALL & de_regwrt & busy_mask[de_rd];
        stall_processor = de_valid & ~flush & (haz1 | haz2 | hazw);
        issue           = de_valid & ~flush & ~stall_processor;
    end

    // Counter update: a new issue overrides, mem_done clears PEND, otherwise count down.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue && de_regwrt && (de_rd == REG_ADDR_W'(r))) begin
                    cnt[r] <= de_lat;
                end else if (mem_done && (mem_done_rd == REG_ADDR_W'(r)) && (cnt[r] == PEND)) begin
                    cnt[r] <= '0;
                end else if ((cnt[r] != '0) && (cnt[r] != PEND)) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // Saturating count of stalled cycles for performance monitoring.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (stall_processor && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - table, directed and randomized checks of hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rstn;
    logic        de_valid;
    logic [4:0]  de_src1;
    logic [4:0]  de_src2;
    logic        de_use_src1;
    logic        de_use_src2;
    logic [4:0]  de_rd;
    logic        de_regwrt;
    logic [2:0]  de_lat;
    logic        flush;
    logic        mem_done;
    logic [4:0]  mem_done_rd;

    logic        stall0;
    logic [31:0] busy0;
    logic [31:0] sc0;
    logic        stall1;
    logic [31:0] busy1;
    logic [3:0]  sc1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut0 (
        .clk(clk), .rstn(rstn), .de_valid(de_valid), .de_src1(de_src1), .de_src2(de_src2),
        .de_use_src1(de_use_src1), .de_use_src2(de_use_src2), .de_rd(de_rd),
        .de_regwrt(de_regwrt), .de_lat(de_lat), .flush(flush), .mem_done(mem_done),
        .mem_done_rd(mem_done_rd), .stall_processor(stall0), .busy_mask(busy0),
        .stall_cycles(sc0)
    );

    hazard_scoreboard #(.WAW_STALL(1'b0), .CNT_W(4)) u_dut1 (
        .clk(clk), .rstn(rstn), .de_valid(de_valid), .de_src1(de_src1), .de_src2(de_src2),
        .de_use_src1(de_use_src1), .de_use_src2(de_use_src2), .de_rd(de_rd),
        .de_regwrt(de_regwrt), .de_lat(de_lat), .flush(flush), .mem_done(mem_done),
        .mem_done_rd(mem_done_rd), .stall_processor(stall1), .busy_mask(busy1),
        .stall_cycles(sc1)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  src1;
        logic        use1;
        logic [4:0]  src2;
        logic        use2;
        logic [4:0]  rd;
        logic        regwrt;
        logic [2:0]  lat;
        logic        flush;
        logic        mdone;
        logic [4:0]  mdrd;
        logic        exp_stall;
        logic [31:0] exp_busy;
        int          exp_cyc;
    } vec_t;

    vec_t tbl[$];

    // Reference model: a register is busy until an absolute ready time, or while pending.
    bit     pend  [2][32];
    longint ready [2][32];
    longint msc   [2];
    longint now;

    function automatic vec_t mk(input logic v, input logic [4:0] s1, input logic u1,
                                input logic [4:0] s2, input logic u2, input logic [4:0] rd,
                                input logic wr, input logic [2:0] lat, input logic fl,
                                input logic md, input logic [4:0] mdrd, input logic es,
                                input logic [31:0] eb, input int ec);
        vec_t t;
        t.valid = v;  t.src1 = s1; t.use1 = u1; t.src2 = s2; t.use2 = u2;
        t.rd = rd;    t.regwrt = wr; t.lat = lat; t.flush = fl;
        t.mdone = md; t.mdrd = mdrd; t.exp_stall = es; t.exp_busy = eb; t.exp_cyc = ec;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        de_valid = t.valid; de_src1 = t.src1; de_use_src1 = t.use1;
        de_src2 = t.src2;   de_use_src2 = t.use2; de_rd = t.rd;
        de_regwrt = t.regwrt; de_lat = t.lat; flush = t.flush;
        mem_done = t.mdone; mem_done_rd = t.mdrd;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    function automatic bit m_busy(input int k, input int r);
        return (r != 0) && (pend[k][r] || (now < ready[k][r]));
    endfunction

    function automatic bit m_stall(input int k);
        bit h;
        h = (de_use_src1 && m_busy(k, int'(de_src1))) ||
            (de_use_src2 && m_busy(k, int'(de_src2))) ||
            ((k == 0) && de_regwrt && m_busy(k, int'(de_rd)));
        return de_valid && !flush && h;
    endfunction

    function automatic logic [31:0] m_mask(input int k);
        logic [31:0] m;
        m = '0;
        for (int r = 0; r < 32; r++) m[r] = m_busy(k, r);
        return m;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            msc[k] = 0;
            for (int r = 0; r < 32; r++) begin
                pend[k][r]  = 1'b0;
                ready[k][r] = 0;
            end
        end
        now = 0;
    endtask

    task automatic model_edge();
        bit     st [2];
        longint nxt;
        for (int k = 0; k < 2; k++) st[k] = m_stall(k);
        nxt = now + 1;
        for (int k = 0; k < 2; k++) begin
            if (mem_done && mem_done_rd != 0 && pend[k][mem_done_rd]) pend[k][mem_done_rd] = 1'b0;
            if (de_valid && !flush && !st[k] && de_regwrt && de_rd != 0) begin
                if (de_lat == 3'd7) begin
                    pend[k][de_rd]  = 1'b1;
                    ready[k][de_rd] = 0;
                end else begin
                    pend[k][de_rd]  = 1'b0;
                    ready[k][de_rd] = nxt + longint'(de_lat);
                end
            end
            if (st[k]) msc[k] = msc[k] + 1;
        end
        if (msc[1] > 15) msc[1] = 15;
        now = nxt;
    endtask

    initial begin
        // Test 1: zero-latency forwarding
        tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,5,1,0,0,6,1,0,0,0,0, 0,0,0));
        // Test 2: two-cycle producer, consumer on src2
        tbl.push_back(mk(1,0,0,0,0,5,1,2,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,5,1,6,1,0,0,0,0, 1,32'(1)<<5,0));
        tbl.push_back(mk(1,0,0,5,1,6,1,0,0,0,0, 1,32'(1)<<5,1));
        tbl.push_back(mk(1,0,0,5,1,6,1,0,0,0,0, 0,0,2));
        // Test 3: pending load, stray mem_done on idle reg, real mem_done in 10th stall cycle
        tbl.push_back(mk(1,0,0,0,0,7,1,7,0,0,0, 0,0,2));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1,7,1,0,0,8,1,0,0, (i==3)||(i==9), (i==9) ? 5'd7 : 5'd8,
                             1,32'(1)<<7,2+i));
        tbl.push_back(mk(1,7,1,0,0,8,1,0,0,0,0, 0,0,12));
        // Test 4: x0 source, unused busy src2, flush, invalid, mem_done on counting reg
        tbl.push_back(mk(1,0,0,0,0,9,1,5,0,0,0, 0,0,12));
        tbl.push_back(mk(1,0,1,9,0,0,1,3,0,0,0, 0,32'(1)<<9,12));
        tbl.push_back(mk(1,9,1,0,0,10,1,0,1,0,0, 0,32'(1)<<9,12));
        tbl.push_back(mk(0,9,1,0,0,10,1,0,0,1,9, 0,32'(1)<<9,12));
        tbl.push_back(mk(1,9,1,0,0,10,1,0,0,0,0, 1,32'(1)<<9,12));
        tbl.push_back(mk(1,9,1,0,0,10,1,0,0,0,0, 1,32'(1)<<9,13));
        tbl.push_back(mk(1,9,1,0,0,10,1,0,0,0,0, 0,0,14));
        // Test 5: WAW stall on the default instance
        tbl.push_back(mk(1,0,0,0,0,3,1,3,0,0,0, 0,0,14));
        tbl.push_back(mk(1,0,0,0,0,3,1,1,0,0,0, 1,32'(1)<<3,14));
        tbl.push_back(mk(1,0,0,0,0,3,1,1,0,0,0, 1,32'(1)<<3,15));
        tbl.push_back(mk(1,0,0,0,0,3,1,1,0,0,0, 1,32'(1)<<3,16));
        tbl.push_back(mk(1,0,0,0,0,3,1,1,0,0,0, 0,0,17));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,32'(1)<<3,17));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,17));

        do_reset();
        @(negedge clk);
        chk("reset_busy0", 64'(busy0), 64'(0));
        chk("reset_sc0", 64'(sc0), 64'(0));
        chk("reset_busy1", 64'(busy1), 64'(0));
        chk("reset_stall0", 64'(stall0), 64'(0));
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("tbl%0d_stall", i), 64'(stall0), 64'(tbl[i].exp_stall));
            chk($sformatf("tbl%0d_busy", i), 64'(busy0), 64'(tbl[i].exp_busy));
            chk($sformatf("tbl%0d_cycles", i), 64'(sc0), 64'(tbl[i].exp_cyc));
            @(posedge clk); #1;
        end

        // Without WAW stall the second write to x3 issues at once and reloads cnt[3] with 1
        do_reset();
        drive(mk(1,0,0,0,0,3,1,3,0,0,0, 0,0,0));
        @(posedge clk); #1;
        drive(mk(1,0,0,0,0,3,1,1,0,0,0, 0,0,0));
        @(negedge clk);
        chk("waw0_stall1", 64'(stall1), 64'(0));
        chk("waw0_stall0", 64'(stall0), 64'(1));
        @(posedge clk); #1;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
        @(negedge clk);
        chk("waw0_busy_a", 64'(busy1), 64'(32'(1)<<3));
        @(posedge clk); #1;
        @(negedge clk);
        chk("waw0_busy_b", 64'(busy1), 64'(0));
        @(posedge clk); #1;

        // Saturation of the 4-bit counter, then asynchronous reset while x4 is pending
        do_reset();
        drive(mk(1,0,0,0,0,4,1,7,0,0,0, 0,0,0));
        @(posedge clk); #1;
        drive(mk(1,4,1,0,0,11,1,0,0,0,0, 0,0,0));
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_sc1", 64'(sc1), 64'(15));
        chk("sat_sc0", 64'(sc0), 64'(20));
        chk("sat_busy1", 64'(busy1), 64'(32'(1)<<4));
        rstn = 1'b0;
        #1;
        chk("areset_busy0", 64'(busy0), 64'(0));
        chk("areset_busy1", 64'(busy1), 64'(0));
        chk("areset_sc0", 64'(sc0), 64'(0));
        chk("areset_sc1", 64'(sc1), 64'(0));
        chk("areset_stall0", 64'(stall0), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;

        // Randomized traffic against the reference model
        do_reset();
        model_clear();
        for (int n = 0; n < 2000; n++) begin
            de_valid    = ($urandom_range(0, 9) < 8);
            de_src1     = 5'($urandom_range(0, 7));
            de_src2     = 5'($urandom_range(0, 7));
            de_use_src1 = 1'($urandom_range(0, 1));
            de_use_src2 = 1'($urandom_range(0, 1));
            de_rd       = 5'($urandom_range(0, 7));
            de_regwrt   = ($urandom_range(0, 9) < 7);
            de_lat      = 3'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 9) == 0);
            mem_done    = ($urandom_range(0, 9) < 3);
            mem_done_rd = 5'($urandom_range(0, 7));
            @(negedge clk);
            chk($sformatf("rnd%0d_stall0", n), 64'(stall0), 64'(m_stall(0)));
            chk($sformatf("rnd%0d_stall1", n), 64'(stall1), 64'(m_stall(1)));
            chk($sformatf("rnd%0d_busy0", n), 64'(busy0), 64'(m_mask(0)));
            chk($sformatf("rnd%0d_busy1", n), 64'(busy1), 64'(m_mask(1)));
            chk($sformatf("rnd%0d_sc0", n), 64'(sc0), 64'(msc[0]));
            chk($sformatf("rnd%0d_sc1", n), 64'(sc1), 64'(msc[1]));
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
